// File: rtl/camera_pixel_pack.sv
// Packs 10-bit camera pixels three per 32-bit FIFO word, with frame/line markers,
// frame framing by frame_sign rising edge, and sticky overflow/framing error flags.
module camera_pixel_pack #(
    parameter int unsigned LINE_PIX = 960,
    parameter int unsigned LINES    = 480
) (
    input  logic        clk_200,
    input  logic        reset,
    input  logic [9:0]  pix_in,
    input  logic        pix_valid,
    input  logic        frame_sign,
    input  logic        fifo_full,
    input  logic        stat_clr,
    output logic [31:0] word_out,
    output logic        word_wrreq,
    output logic        frame_done,
    output logic        overflow,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int unsigned PIX_W  = 10;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned FCNT_W = 16;

    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(LINE_PIX - 1);
    localparam logic [CNT_W-1:0]  LAST_LINE = CNT_W'(LINES - 1);
    localparam logic [SLOT_W-1:0] SLOT_2    = SLOT_W'(2);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                frame_sign_d;
    logic                fs_rise;
    logic [CNT_W-1:0]    pix_cnt;
    logic [CNT_W-1:0]    line_cnt;
    logic [SLOT_W-1:0]   slot;
    logic [PIX_W-1:0]    slot0_q;
    logic [PIX_W-1:0]    slot1_q;
    logic                first_pend;
    logic                accept;
    logic                last_pix;
    logic                last_line;
    logic                emit;
    logic [WORD_W-1:0]   word_nxt;

    assign fs_rise = frame_sign & ~frame_sign_d;

    // Next state, pixel acceptance and the word that the current pixel would complete
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        last_pix  = (pix_cnt == LAST_PIX);
        last_line = (line_cnt == LAST_LINE);
        word_nxt  = '0;

        case (state)
            IDLE: begin
                if (fs_rise) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!fs_rise && pix_valid) begin
                    accept = 1'b1;
                    emit   = (slot == SLOT_2) || last_pix;
                    if (last_pix && last_line) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        word_nxt[31]    = last_pix;
        word_nxt[30]    = first_pend;
        word_nxt[9:0]   = (slot == SLOT_W'(0)) ? pix_in : slot0_q;
        word_nxt[19:10] = (slot == SLOT_W'(1)) ? pix_in :
                          (slot == SLOT_2)     ? slot1_q : PIX_W'(0);
        word_nxt[29:20] = (slot == SLOT_2) ? pix_in : PIX_W'(0);
    end

    always_ff @(posedge clk_200) begin
        if (!reset) begin
            state        <= IDLE;
            frame_sign_d <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            slot         <= '0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            first_pend   <= 1'b0;
            word_out     <= '0;
            word_wrreq   <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            frame_sign_d <= frame_sign;
            word_wrreq   <= 1'b0;
            frame_done   <= 1'b0;

            // A frame marker always restarts packing; any partial word is lost
            if (fs_rise) begin
                pix_cnt    <= '0;
                line_cnt   <= '0;
                slot       <= '0;
                first_pend <= 1'b1;
            end else if (accept) begin
                if (slot == SLOT_W'(0)) slot0_q <= pix_in;
                if (slot == SLOT_W'(1)) slot1_q <= pix_in;
                slot    <= emit ? SLOT_W'(0) : slot + SLOT_W'(1);
                pix_cnt <= last_pix ? CNT_W'(0) : pix_cnt + CNT_W'(1);
                if (last_pix) begin
                    line_cnt <= last_line ? CNT_W'(0) : line_cnt + CNT_W'(1);
                end
                if (emit) begin
                    first_pend <= 1'b0;
                    if (!fifo_full) begin
                        word_out   <= word_nxt;
                        word_wrreq <= 1'b1;
                    end
                end
                if (last_pix && last_line) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + FCNT_W'(1);
                end
            end

            // Set events take priority over a simultaneous clear
            if (accept && emit && fifo_full) begin
                overflow <= 1'b1;
            end else if (stat_clr) begin
                overflow <= 1'b0;
            end

            if (fs_rise && (state == ACTIVE)) begin
                frame_err <= 1'b1;
            end else if (stat_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_camera_pixel_pack.sv
// Directed self-checking bench for camera_pixel_pack with a 5-pixel x 2-line frame.
module tb_camera_pixel_pack;

    localparam int unsigned LINE_PIX = 5;
    localparam int unsigned LINES    = 2;

    // Pixels 1..10 packed per slot layout [9:0],[19:10],[29:20], bit30 first, bit31 end-of-line
    localparam logic [31:0] W1 = 32'h4030_0801;
    localparam logic [31:0] W2 = 32'h8000_1404;
    localparam logic [31:0] W3 = 32'h0080_1C06;
    localparam logic [31:0] W4 = 32'h8000_2809;

    logic        clk_200 = 1'b0;
    logic        reset;
    logic [9:0]  pix_in;
    logic        pix_valid;
    logic        frame_sign;
    logic        fifo_full;
    logic        stat_clr;
    logic [31:0] word_out;
    logic        word_wrreq;
    logic        frame_done;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_200 = ~clk_200;

    camera_pixel_pack #(
        .LINE_PIX (LINE_PIX),
        .LINES    (LINES)
    ) dut (
        .clk_200    (clk_200),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .frame_sign (frame_sign),
        .fifo_full  (fifo_full),
        .stat_clr   (stat_clr),
        .word_out   (word_out),
        .word_wrreq (word_wrreq),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_for(input int i);
        case (i)
            3:       return W1;
            5:       return W2;
            8:       return W3;
            10:      return W4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic send(input logic [9:0] v, input logic full, input logic exp_wr,
                        input logic [31:0] exp_word, input logic exp_done, input string tag);
        pix_in    = v;
        pix_valid = 1'b1;
        fifo_full = full;
        @(posedge clk_200);
        #1;
        pix_valid = 1'b0;
        fifo_full = 1'b0;
        chk({tag, "_wrreq"}, 32'(word_wrreq), 32'(exp_wr));
        chk({tag, "_word"},  word_out, exp_word);
        chk({tag, "_done"},  32'(frame_done), 32'(exp_done));
    endtask

    task automatic idle(input string tag);
        pix_valid = 1'b0;
        @(posedge clk_200);
        #1;
        chk({tag, "_idle_wrreq"}, 32'(word_wrreq), 32'h0);
    endtask

    task automatic fs_start(input logic with_pix, input string tag);
        frame_sign = 1'b1;
        pix_valid  = with_pix;
        pix_in     = 10'h155;
        @(posedge clk_200);
        #1;
        frame_sign = 1'b0;
        pix_valid  = 1'b0;
        chk({tag, "_wrreq"}, 32'(word_wrreq), 32'h0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_word"},      word_out, 32'h0);
        chk({tag, "_wrreq"},     32'(word_wrreq), 32'h0);
        chk({tag, "_done"},      32'(frame_done), 32'h0);
        chk({tag, "_overflow"},  32'(overflow), 32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
    endtask

    // Pixels 1..10; fifo_full held over [full_lo..full_hi]; gaps of (i mod (gap_max+1)) idle cycles
    task automatic run_frame(input string tag, input int gap_max, input int full_lo,
                             input int full_hi, input logic [31:0] prev);
        logic [31:0] held;
        logic        full;
        logic        wr;
        held = prev;
        for (int i = 1; i <= 10; i++) begin
            full = (i >= full_lo) && (i <= full_hi);
            wr   = ((i == 3) || (i == 5) || (i == 8) || (i == 10)) && !full;
            if (wr) held = word_for(i);
            send(10'(i), full, wr, held, (i == 10), $sformatf("%s_p%0d", tag, i));
            if (gap_max > 0) begin
                for (int g = 0; g < (i % (gap_max + 1)); g++) idle(tag);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        pix_in     = '0;
        pix_valid  = 1'b0;
        frame_sign = 1'b0;
        fifo_full  = 1'b0;
        stat_clr   = 1'b0;
        repeat (3) @(posedge clk_200);
        #1;
        check_zero("reset");
        reset = 1'b1;

        // Pixels before any frame marker, and one coincident with it, are ignored
        for (int i = 0; i < 3; i++) send(10'h3FF, 1'b0, 1'b0, 32'h0, 1'b0, "pre_frame");
        fs_start(1'b1, "fs1");
        run_frame("f1", 0, 0, 0, 32'h0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_overflow",  32'(overflow),  32'h0);
        chk("f1_frame_err", 32'(frame_err), 32'h0);

        // Gapped pixel stream yields the same words
        fs_start(1'b0, "fs2");
        run_frame("f2", 3, 0, 0, W4);
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);

        // FIFO full from pixel 6 through word 3's completing pixel drops only that word
        fs_start(1'b0, "fs3");
        run_frame("f3", 0, 6, 8, W4);
        chk("f3_overflow",  32'(overflow),  32'h1);
        chk("f3_frame_cnt", 32'(frame_cnt), 32'd3);
        stat_clr = 1'b1;
        idle("clr");
        stat_clr = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'h0);

        // Restart after pixel 4 flags a framing error and discards the partial word
        fs_start(1'b0, "fs4");
        for (int i = 1; i <= 4; i++) begin
            send(10'(i), 1'b0, (i == 3), (i >= 3) ? W1 : W4, 1'b0, $sformatf("abort_p%0d", i));
        end
        fs_start(1'b1, "fs_abort");
        chk("abort_frame_err", 32'(frame_err), 32'h1);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd3);
        run_frame("f4", 0, 0, 0, W1);
        chk("f4_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("f4_frame_err", 32'(frame_err), 32'h1);

        // Reset mid-frame clears everything; no words until a new frame marker
        fs_start(1'b0, "fs5");
        for (int i = 1; i <= 7; i++) begin
            send(10'(i), 1'b0, (i == 3) || (i == 5), (i >= 5) ? W2 : (i >= 3) ? W1 : W4,
                 1'b0, $sformatf("mid_p%0d", i));
        end
        reset = 1'b0;
        @(posedge clk_200);
        #1;
        reset = 1'b1;
        check_zero("mid_reset");
        for (int i = 8; i <= 10; i++) send(10'(i), 1'b0, 1'b0, 32'h0, 1'b0, "post_reset");

        // Overflow set wins over a same-cycle stat_clr
        fs_start(1'b0, "fs6");
        send(10'd1, 1'b0, 1'b0, 32'h0, 1'b0, "race_p1");
        send(10'd2, 1'b0, 1'b0, 32'h0, 1'b0, "race_p2");
        stat_clr = 1'b1;
        send(10'd3, 1'b1, 1'b0, 32'h0, 1'b0, "race_p3");
        stat_clr = 1'b0;
        chk("race_overflow", 32'(overflow), 32'h1);
        stat_clr = 1'b1;
        idle("race_clr");
        stat_clr = 1'b0;
        chk("race_clr_overflow", 32'(overflow), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
